// File: rtl/plca_ctrl_pkg.sv
// Shared encodings for the PLCA transmit-opportunity controller.
// State codes are visible on the state port, so their values are fixed.
package plca_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_DISABLE       = 4'd0,
        ST_RESYNC        = 4'd1,
        ST_RECOVER       = 4'd2,
        ST_SEND_BEACON   = 4'd3,
        ST_SYNCING       = 4'd4,
        ST_WAIT_TO       = 4'd5,
        ST_EARLY_RECEIVE = 4'd6,
        ST_COMMIT        = 4'd7,
        ST_YIELD         = 4'd8,
        ST_RECEIVE       = 4'd9,
        ST_TRANSMIT      = 4'd10,
        ST_BURST         = 4'd11,
        ST_NEXT_TO       = 4'd12,
        ST_ABORT         = 4'd13
    } plca_state_t;

    typedef enum logic [1:0] {
        CMD_BEACON = 2'b00,
        CMD_COMMIT = 2'b01,
        CMD_NONE   = 2'b10
    } plca_cmd_t;

    localparam int STATS_W = 16;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/plca_ctrl_timer.sv
// Down-counting one-shot timer: done holds once LEN cycles have elapsed since start.
// Latency: start loads on the edge, done is seen LEN-1 edges later; start beats done (restart).
// Backpressure: none; stop (or reset) disarms the timer and clears done.
module plca_ctrl_timer #(
    parameter int LEN = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic stop,
    output logic done
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_armed;

    always_ff @(posedge clk) begin
        if (!reset_n || stop) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (start) begin
            r_cnt   <= CW'(LEN - 1);
            r_armed <= 1'b1;
        end else if (r_armed && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign done = r_armed && (r_cnt == '0);

endmodule

// File: rtl/plca_ctrl_sync.sv
// PLCA TO-cycle controller (beacon, commit, burst, yield, receive); PLCA_CTRL_STATS_EN adds counters.
// Latency: registered Moore FSM, outputs follow the causing input by one clk.
// Backpressure: none; TX_EN/CRS/packetPending are sampled every cycle.
module plca_ctrl_sync
    import plca_ctrl_pkg::*;
#(
    parameter int ID_W           = 8,
    parameter int TO_CYC         = 32,
    parameter int BEACON_CYC     = 20,
    parameter int BEACON_DET_CYC = 22,
    parameter int INV_BEACON_CYC = 4000,
    parameter int BURST_CYC      = 128
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            plca_en,
    input  logic [ID_W-1:0] local_nodeID,
    input  logic [ID_W-1:0] plca_node_count,
    input  logic [ID_W-1:0] max_bc,
    input  logic            PMCD,
    input  logic            CRS,
    input  logic            TX_EN,
    input  logic            packetPending,
    input  logic            receiving,
    input  logic [1:0]      rx_cmd,
    output logic [3:0]      state,
    output logic [1:0]      tx_cmd,
    output logic            committed,
    output logic [ID_W-1:0] curID,
    output logic            plca_active,
    output logic [ID_W-1:0] bc,
    output logic            to_end
`ifdef PLCA_CTRL_STATS_EN
    ,
    output logic [15:0]     beacon_cnt,
    output logic [15:0]     resync_cnt
`endif
);

    plca_state_t     r_state;
    plca_state_t     w_next;
    plca_cmd_t       r_tx_cmd;
    plca_cmd_t       w_tx_cmd_n;
    logic            r_committed, w_committed_n;
    logic [ID_W-1:0] r_cur_id, w_cur_id_n;
    logic [ID_W-1:0] r_bc, w_bc_n;
    logic            r_active, w_active_n;
    logic            r_to_end, w_to_end_n;

    logic w_dis, w_node0, w_my_to, w_enter, w_inv_fire;
    logic w_to_done, w_bcn_done, w_bdet_done, w_inv_done, w_burst_done;
    logic w_to_start, w_to_stop, w_bcn_start, w_bdet_start, w_inv_start, w_burst_start;

    assign w_dis      = !plca_en || (&local_nodeID);
    assign w_node0    = (local_nodeID == '0);
    assign w_my_to    = (r_cur_id == local_nodeID);
    assign w_inv_fire = w_inv_done && (r_state != ST_DISABLE);

    always_ff @(posedge clk) begin
        if (!reset_n || w_dis) begin
            r_state <= ST_DISABLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Invalid-beacon expiry overrides every other transition.
    always_comb begin
        w_next = r_state;
        if (w_inv_fire) begin
            w_next = ST_RESYNC;
        end else begin
            case (r_state)
                ST_DISABLE:     w_next = w_node0 ? ST_RECOVER : ST_RESYNC;
                ST_RESYNC: begin
                    if (w_node0 && PMCD && !CRS && !TX_EN) w_next = ST_SEND_BEACON;
                    else if (!w_node0 && CRS)              w_next = ST_EARLY_RECEIVE;
                end
                ST_RECOVER:     w_next = ST_WAIT_TO;
                ST_SEND_BEACON: if (w_bcn_done) w_next = ST_SYNCING;
                ST_SYNCING:     if (!CRS) w_next = ST_WAIT_TO;
                ST_WAIT_TO: begin
                    if (CRS)                                      w_next = ST_EARLY_RECEIVE;
                    else if (w_my_to && r_active && packetPending) w_next = ST_COMMIT;
                    else if (w_my_to)                             w_next = ST_YIELD;
                    else if (w_to_done)                           w_next = ST_NEXT_TO;
                end
                ST_EARLY_RECEIVE: begin
                    if (receiving && CRS)
                        w_next = ST_RECEIVE;
                    else if (!w_node0 && !receiving &&
                             ((rx_cmd == CMD_BEACON) || (!CRS && !w_bdet_done)))
                        w_next = ST_SYNCING;
                    else if (!CRS && w_node0)
                        w_next = ST_RECOVER;
                    else if (!CRS && !w_node0 && w_bdet_done)
                        w_next = ST_RESYNC;
                end
                ST_COMMIT: begin
                    if (TX_EN)               w_next = ST_TRANSMIT;
                    else if (!packetPending) w_next = ST_ABORT;
                end
                ST_YIELD: begin
                    if (w_to_done) w_next = ST_NEXT_TO;
                    else if (CRS)  w_next = ST_EARLY_RECEIVE;
                end
                ST_RECEIVE: begin
                    if ((rx_cmd == CMD_BEACON) && !w_node0) w_next = ST_SYNCING;
                    else if (!CRS)                          w_next = ST_NEXT_TO;
                end
                ST_TRANSMIT: begin
                    if (!TX_EN && (r_bc < max_bc)) w_next = ST_BURST;
                    else if (!TX_EN && !CRS)       w_next = ST_NEXT_TO;
                end
                ST_BURST: begin
                    if (TX_EN)             w_next = ST_TRANSMIT;
                    else if (w_burst_done) w_next = ST_ABORT;
                end
                ST_ABORT:   if (!CRS) w_next = ST_NEXT_TO;
                ST_NEXT_TO: w_next = (w_node0 && (r_cur_id >= plca_node_count)) ? ST_RESYNC : ST_WAIT_TO;
                default:    w_next = ST_DISABLE;
            endcase
        end
    end

    assign w_enter = (w_next != r_state);

    // Entry actions: computed from the state being entered, registered on the same edge.
    always_comb begin
        w_tx_cmd_n    = r_tx_cmd;
        w_committed_n = r_committed;
        w_cur_id_n    = r_cur_id;
        w_bc_n        = r_bc;
        w_active_n    = r_active;
        w_to_end_n    = 1'b0;
        w_to_start    = 1'b0;
        w_to_stop     = 1'b0;
        w_bcn_start   = 1'b0;
        w_bdet_start  = 1'b0;
        w_inv_start   = 1'b0;
        w_burst_start = 1'b0;
        if (w_enter) begin
            case (w_next)
                ST_RESYNC, ST_RECOVER: w_active_n = 1'b0;
                ST_SEND_BEACON: begin
                    w_tx_cmd_n  = CMD_BEACON;
                    w_active_n  = 1'b1;
                    w_bcn_start = 1'b1;
                end
                ST_SYNCING: begin
                    w_cur_id_n  = '0;
                    w_tx_cmd_n  = CMD_NONE;
                    w_active_n  = 1'b1;
                    w_inv_start = !w_node0 && (rx_cmd != CMD_BEACON);
                end
                ST_WAIT_TO:       w_to_start = 1'b1;
                ST_EARLY_RECEIVE: begin
                    w_to_stop    = 1'b1;
                    w_bdet_start = 1'b1;
                end
                ST_COMMIT: begin
                    w_tx_cmd_n    = CMD_COMMIT;
                    w_committed_n = 1'b1;
                    w_bc_n        = '0;
                end
                ST_TRANSMIT: begin
                    w_tx_cmd_n = CMD_NONE;
                    if (r_bc >= max_bc) w_committed_n = 1'b0;
                end
                ST_BURST: begin
                    w_bc_n        = (&r_bc) ? r_bc : r_bc + ID_W'(1);
                    w_tx_cmd_n    = CMD_COMMIT;
                    w_burst_start = 1'b1;
                end
                ST_ABORT: begin
                    w_tx_cmd_n    = CMD_NONE;
                    w_committed_n = 1'b0;
                end
                ST_NEXT_TO: begin
                    w_cur_id_n    = r_cur_id + ID_W'(1);
                    w_committed_n = 1'b0;
                    w_to_end_n    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || w_dis) begin
            r_tx_cmd    <= CMD_NONE;
            r_committed <= 1'b0;
            r_cur_id    <= '0;
            r_bc        <= '0;
            r_active    <= 1'b0;
            r_to_end    <= 1'b0;
        end else begin
            r_tx_cmd    <= w_tx_cmd_n;
            r_committed <= w_committed_n;
            r_cur_id    <= w_cur_id_n;
            r_bc        <= w_bc_n;
            r_active    <= w_active_n;
            r_to_end    <= w_to_end_n;
        end
    end

    plca_ctrl_timer #(.LEN(TO_CYC)) u_to_timer (
        .clk(clk), .reset_n(reset_n), .start(w_to_start),
        .stop(w_dis || w_to_stop), .done(w_to_done)
    );

    plca_ctrl_timer #(.LEN(BEACON_CYC)) u_beacon_timer (
        .clk(clk), .reset_n(reset_n), .start(w_bcn_start),
        .stop(w_dis), .done(w_bcn_done)
    );

    plca_ctrl_timer #(.LEN(BEACON_DET_CYC)) u_beacon_det_timer (
        .clk(clk), .reset_n(reset_n), .start(w_bdet_start),
        .stop(w_dis), .done(w_bdet_done)
    );

    // Disarmed as it fires so a single expiry forces exactly one resync.
    plca_ctrl_timer #(.LEN(INV_BEACON_CYC)) u_inv_beacon_timer (
        .clk(clk), .reset_n(reset_n), .start(w_inv_start),
        .stop(w_dis || w_inv_fire), .done(w_inv_done)
    );

    plca_ctrl_timer #(.LEN(BURST_CYC)) u_burst_timer (
        .clk(clk), .reset_n(reset_n), .start(w_burst_start),
        .stop(w_dis), .done(w_burst_done)
    );

`ifdef PLCA_CTRL_STATS_EN
    logic [STATS_W-1:0] r_beacon_cnt, r_resync_cnt;
    logic               w_bcn_evt;

    assign w_bcn_evt = (w_enter && (w_next == ST_SEND_BEACON)) ||
                       ((r_state == ST_EARLY_RECEIVE) && (rx_cmd == CMD_BEACON) &&
                        (w_next == ST_SYNCING));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_beacon_cnt <= '0;
            r_resync_cnt <= '0;
        end else begin
            if (w_bcn_evt)  r_beacon_cnt <= sat_inc(r_beacon_cnt);
            if (w_inv_fire) r_resync_cnt <= sat_inc(r_resync_cnt);
        end
    end

    assign beacon_cnt = r_beacon_cnt;
    assign resync_cnt = r_resync_cnt;
`endif

    assign state       = r_state;
    assign tx_cmd      = r_tx_cmd;
    assign committed   = r_committed;
    assign curID       = r_cur_id;
    assign plca_active = r_active;
    assign bc          = r_bc;
    assign to_end      = r_to_end;

endmodule

// File: tb/tb_plca_ctrl_sync.sv
// Directed bench for plca_ctrl_sync at default parameters; expected values are hand-derived cycle counts.
module tb_plca_ctrl_sync;

    localparam logic [3:0] S_DISABLE = 4'd0,  S_RESYNC = 4'd1,  S_RECOVER = 4'd2,
                           S_SEND_BEACON = 4'd3, S_SYNCING = 4'd4, S_WAIT_TO = 4'd5,
                           S_EARLY_RX = 4'd6, S_COMMIT = 4'd7,  S_YIELD = 4'd8,
                           S_TRANSMIT = 4'd10, S_BURST = 4'd11, S_NEXT_TO = 4'd12,
                           S_ABORT = 4'd13;
    localparam logic [1:0] C_BEACON = 2'b00, C_COMMIT = 2'b01, C_NONE = 2'b10;

    logic       clk = 1'b0;
    logic       reset_n, plca_en, PMCD, CRS, TX_EN, packetPending, receiving;
    logic [7:0] local_nodeID, plca_node_count, max_bc;
    logic [1:0] rx_cmd;
    logic [3:0] state;
    logic [1:0] tx_cmd;
    logic       committed, plca_active, to_end;
    logic [7:0] curID, bc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    plca_ctrl_sync #(
        .ID_W(8), .TO_CYC(32), .BEACON_CYC(20), .BEACON_DET_CYC(22),
        .INV_BEACON_CYC(4000), .BURST_CYC(128)
    ) dut (
        .clk(clk), .reset_n(reset_n), .plca_en(plca_en), .local_nodeID(local_nodeID),
        .plca_node_count(plca_node_count), .max_bc(max_bc), .PMCD(PMCD), .CRS(CRS),
        .TX_EN(TX_EN), .packetPending(packetPending), .receiving(receiving), .rx_cmd(rx_cmd),
        .state(state), .tx_cmd(tx_cmd), .committed(committed), .curID(curID),
        .plca_active(plca_active), .bc(bc), .to_end(to_end)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, state, S_DISABLE);
        chk({tag, "_txcmd"}, tx_cmd, C_NONE);
        chk({tag, "_committed"}, committed, 0);
        chk({tag, "_curid"}, curID, 0);
        chk({tag, "_active"}, plca_active, 0);
        chk({tag, "_bc"}, bc, 0);
        chk({tag, "_toend"}, to_end, 0);
    endtask

    // Reset, then sync a non-zero node via a carrier burst carrying rx (BEACON or NONE).
    // Ends one edge after entering WAIT_TO with curID=0.
    task automatic bring_up(input logic [7:0] id, input logic [1:0] rx);
        reset_n = 1'b0; plca_en = 1'b1; local_nodeID = id;
        CRS = 1'b0; TX_EN = 1'b0; receiving = 1'b0; rx_cmd = C_NONE;
        tick(); tick();
        reset_n = 1'b1;
        tick(); chk("up_resync", state, S_RESYNC);
        CRS = 1'b1; rx_cmd = rx;
        tick(); chk("up_early_rx", state, S_EARLY_RX);
        CRS = 1'b0;
        tick(); chk("up_syncing", state, S_SYNCING); chk("up_active", plca_active, 1);
        rx_cmd = C_NONE;
        tick(); chk("up_wait_to", state, S_WAIT_TO); chk("up_curid", curID, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; plca_en = 1'b1; local_nodeID = 8'd0; plca_node_count = 8'd4;
        max_bc = 8'd0; PMCD = 1'b1; CRS = 1'b0; TX_EN = 1'b0; packetPending = 1'b0;
        receiving = 1'b0; rx_cmd = C_NONE;
        tick(); tick();
        chk_reset("rst");

        // Node 0 on an idle line: yields its own TO, walks curID up to node_count, then beacons.
        reset_n = 1'b1;
        tick(); chk("n0_recover", state, S_RECOVER);
        tick(); chk("n0_wait", state, S_WAIT_TO);
        tick(); chk("n0_yield", state, S_YIELD);
        repeat (30) tick();
        chk("n0_yield_hold", state, S_YIELD); chk("n0_toend_lo", to_end, 0);
        tick(); chk("n0_next1", state, S_NEXT_TO); chk("n0_curid1", curID, 1); chk("n0_toend_hi", to_end, 1);
        tick(); chk("n0_wait1", state, S_WAIT_TO); chk("n0_toend_pulse", to_end, 0);
        for (int id = 2; id <= 4; id++) begin
            repeat (31) tick();
            chk("n0_to_hold", state, S_WAIT_TO);
            tick(); chk("n0_next", state, S_NEXT_TO); chk("n0_curid", curID, id);
            tick(); chk("n0_after_next", state, (id < 4) ? S_WAIT_TO : S_RESYNC);
        end
        chk("n0_resync_inactive", plca_active, 0);
        tick(); chk("n0_beacon", state, S_SEND_BEACON); chk("n0_bcn_cmd", tx_cmd, C_BEACON);
        chk("n0_bcn_active", plca_active, 1);
        repeat (19) tick();
        chk("n0_bcn_hold", state, S_SEND_BEACON); chk("n0_bcn_cmd_hold", tx_cmd, C_BEACON);
        tick(); chk("n0_syncing", state, S_SYNCING); chk("n0_sync_cmd", tx_cmd, C_NONE);
        chk("n0_sync_curid", curID, 0);
        tick(); chk("n0_wait_again", state, S_WAIT_TO);

        // Node 2 commits on its TO, single frame with bursts disabled.
        packetPending = 1'b1; max_bc = 8'd0;
        bring_up(8'd2, C_BEACON);
        repeat (66) tick();
        chk("n2_wait_own", state, S_WAIT_TO); chk("n2_curid2", curID, 2);
        tick(); chk("n2_commit", state, S_COMMIT); chk("n2_commit_cmd", tx_cmd, C_COMMIT);
        chk("n2_committed", committed, 1); chk("n2_bc0", bc, 0);
        TX_EN = 1'b1;
        tick(); chk("n2_transmit", state, S_TRANSMIT); chk("n2_tx_cmd_none", tx_cmd, C_NONE);
        chk("n2_uncommit_bc0", committed, 0);
        repeat (3) tick();
        chk("n2_tx_hold", state, S_TRANSMIT);
        TX_EN = 1'b0;
        tick(); chk("n2_next", state, S_NEXT_TO); chk("n2_curid3", curID, 3); chk("n2_toend", to_end, 1);
        tick(); chk("n2_wait", state, S_WAIT_TO); chk("n2_toend_once", to_end, 0);

        // Management disable mid-cycle, re-enable as node 5, then an unassigned ID.
        plca_en = 1'b0;
        tick(); chk("dis_state", state, S_DISABLE); chk("dis_curid", curID, 0);
        chk("dis_active", plca_active, 0);
        local_nodeID = 8'd5; plca_en = 1'b1;
        tick(); chk("reen_resync", state, S_RESYNC);
        local_nodeID = 8'hFF;
        tick(); chk("unassigned_dis", state, S_DISABLE);

        // Node 1 burst chain with max_bc=2.
        max_bc = 8'd2;
        bring_up(8'd1, C_BEACON);
        repeat (33) tick();
        chk("b_wait_own", state, S_WAIT_TO); chk("b_curid1", curID, 1);
        tick(); chk("b_commit", state, S_COMMIT);
        TX_EN = 1'b1;
        tick(); chk("b_tx0", state, S_TRANSMIT); chk("b_bc0", bc, 0); chk("b_keep_commit0", committed, 1);
        TX_EN = 1'b0;
        tick(); chk("b_burst1", state, S_BURST); chk("b_bc1", bc, 1); chk("b_burst_cmd", tx_cmd, C_COMMIT);
        TX_EN = 1'b1;
        tick(); chk("b_tx1", state, S_TRANSMIT); chk("b_bc1_tx", bc, 1); chk("b_keep_commit1", committed, 1);
        TX_EN = 1'b0;
        tick(); chk("b_burst2", state, S_BURST); chk("b_bc2", bc, 2);
        TX_EN = 1'b1;
        tick(); chk("b_tx2", state, S_TRANSMIT); chk("b_drop_commit", committed, 0);
        TX_EN = 1'b0;
        tick(); chk("b_next", state, S_NEXT_TO); chk("b_curid2", curID, 2); chk("b_toend", to_end, 1);

        // Burst window expires with no frame: ABORT.
        bring_up(8'd1, C_BEACON);
        repeat (34) tick();
        chk("ab_commit", state, S_COMMIT);
        TX_EN = 1'b1; tick();
        TX_EN = 1'b0; tick();
        chk("ab_burst", state, S_BURST);
        repeat (127) tick();
        chk("ab_burst_hold", state, S_BURST);
        tick(); chk("ab_abort", state, S_ABORT); chk("ab_cmd", tx_cmd, C_NONE); chk("ab_uncommit", committed, 0);
        tick(); chk("ab_next", state, S_NEXT_TO); chk("ab_curid", curID, 2);

        // One-cycle reset in the middle of a burst transmit.
        bring_up(8'd1, C_BEACON);
        repeat (34) tick();
        chk("rs_commit", state, S_COMMIT);
        TX_EN = 1'b1; tick();
        TX_EN = 1'b0; tick();
        TX_EN = 1'b1; tick();
        chk("rs_transmit", state, S_TRANSMIT); chk("rs_bc1", bc, 1);
        reset_n = 1'b0;
        tick(); chk_reset("rs_mid_tx");
        reset_n = 1'b1; TX_EN = 1'b0;
        tick(); chk("rs_resync", state, S_RESYNC);

        // Node 3 synced from a non-beacon carrier: invalid-beacon expiry after 4000 cycles.
        max_bc = 8'd0; packetPending = 1'b0;
        bring_up(8'd3, C_NONE);
        repeat (3998) tick();
        chk("ib_active_before", plca_active, 1); chk("ib_not_resync_yet", state == S_RESYNC, 0);
        tick(); chk("ib_resync", state, S_RESYNC); chk("ib_inactive", plca_active, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
